// File: rtl/fc_stream_pkg.sv
// rtl/fc_stream_pkg.sv - shared state type, default sizes and sign-extension helper for fc_stream_engine
package fc_stream_pkg;

   typedef enum logic {S_FETCH, S_ROW} fc_state_e;

   localparam int FC_ROW_LEN  = 26;
   localparam int FC_NUM_ROWS = 26;
   localparam int FC_NUM_CLS  = 10;
   localparam int FC_IN_W     = 32;
   localparam int FC_WT_W     = 8;
   localparam int FC_ACC_W    = 32;
   localparam int FC_ADDR_W   = $clog2(FC_NUM_ROWS);
   localparam int FC_CLS_W    = $clog2(FC_NUM_CLS);

   // Sign-extend the low w bits of v to 64 bits.
   function automatic logic [63:0] sext(input logic [63:0] v, input int w);
      logic signed [63:0] t;
      t = $signed(v << (64 - w));
      return t >>> (64 - w);
   endfunction

endpackage

// File: rtl/fc_dot_row.sv
// rtl/fc_dot_row.sv - combinational signed dot product of one row against one class weight vector
module fc_dot_row #(
   parameter int ROW_LEN = 26,
   parameter int IN_W    = 32,
   parameter int WT_W    = 8,
   parameter int ACC_W   = 32
) (
   input  logic [ROW_LEN*IN_W-1:0] i_row,
   input  logic [ROW_LEN*WT_W-1:0] i_wt,
   output logic [ACC_W-1:0]        o_dot
);

   localparam int PW = IN_W + WT_W;

   logic signed [PW-1:0] prod;

   // Full-precision products, truncated into the wrapping accumulator width.
   always_comb begin
      o_dot = '0;
      prod  = '0;
      for (int j = 0; j < ROW_LEN; j++) begin
         prod  = PW'($signed(i_row[j*IN_W +: IN_W])) * PW'($signed(i_wt[j*WT_W +: WT_W]));
         o_dot = o_dot + ACC_W'(prod);
      end
   end

endmodule

// File: rtl/fc_stream_engine.sv
// rtl/fc_stream_engine.sv - row-streaming fully-connected stage with weight RAM fetch; FC_ARGMAX_EN adds registered argmax
module fc_stream_engine
   import fc_stream_pkg::*;
#(
   parameter int ROW_LEN  = FC_ROW_LEN,
   parameter int NUM_ROWS = FC_NUM_ROWS,
   parameter int NUM_CLS  = FC_NUM_CLS,
   parameter int IN_W     = FC_IN_W,
   parameter int WT_W     = FC_WT_W,
   parameter int ACC_W    = FC_ACC_W
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic                             i_row_valid,
   output logic                             o_row_ready,
   input  logic [ROW_LEN*IN_W-1:0]          i_row_data,
   output logic                             o_wt_rd,
   output logic [$clog2(NUM_ROWS)-1:0]      o_wt_addr,
   input  logic [NUM_CLS*ROW_LEN*WT_W-1:0]  i_wt_data,
   input  logic [NUM_CLS*WT_W-1:0]          i_bias,
   output logic                             o_res_valid,
   input  logic                             i_res_ready,
   output logic [NUM_CLS*ACC_W-1:0]         o_res,
   output logic [$clog2(NUM_CLS)-1:0]       o_cls
);

   localparam int AW   = $clog2(NUM_ROWS);
   localparam int CW   = $clog2(NUM_CLS);
   localparam int WROW = ROW_LEN * WT_W;

   fc_state_e                     state_q, state_d;
   logic [AW-1:0]                 row_cnt_q, row_cnt_d;
   logic [NUM_CLS-1:0][ACC_W-1:0] acc_q, acc_d;
   logic [NUM_CLS-1:0][ACC_W-1:0] res_q, res_d;
   logic                          res_valid_q, res_valid_d;
   wire  [NUM_CLS-1:0][ACC_W-1:0] dot;
   wire  [NUM_CLS-1:0][ACC_W-1:0] bias_ext;
   wire  [NUM_CLS-1:0][ACC_W-1:0] score;
   logic                          last_row, row_fire;

   for (genvar k = 0; k < NUM_CLS; k++) begin : g_cls
      fc_dot_row #(
         .ROW_LEN (ROW_LEN),
         .IN_W    (IN_W),
         .WT_W    (WT_W),
         .ACC_W   (ACC_W)
      ) u_dot (
         .i_row (i_row_data),
         .i_wt  (i_wt_data[k*WROW +: WROW]),
         .o_dot (dot[k])
      );
      assign bias_ext[k] = ACC_W'(sext(64'(i_bias[k*WT_W +: WT_W]), WT_W));
      assign score[k]    = acc_q[k] + dot[k] + bias_ext[k];
   end

   assign last_row    = (row_cnt_q == AW'(NUM_ROWS - 1));
   // Last row must wait while the single-entry result buffer is full and not being drained.
   assign o_row_ready = (state_q == S_ROW) && !(last_row && res_valid_q && !i_res_ready);
   assign row_fire    = i_row_valid && o_row_ready;
   // Gated by reset so no read strobe is presented while the block is held in reset.
   assign o_wt_rd     = i_rst_n && (state_q == S_FETCH);
   assign o_wt_addr   = row_cnt_q;
   assign o_res_valid = res_valid_q;
   assign o_res       = res_q;

   always_comb begin
      state_d     = state_q;
      row_cnt_d   = row_cnt_q;
      acc_d       = acc_q;
      res_d       = res_q;
      res_valid_d = res_valid_q && !i_res_ready;
      case (state_q)
         S_FETCH: state_d = S_ROW;
         S_ROW: begin
            if (row_fire) begin
               state_d = S_FETCH;
               if (last_row) begin
                  res_d       = score;
                  acc_d       = '0;
                  row_cnt_d   = '0;
                  res_valid_d = 1'b1;
               end else begin
                  for (int k = 0; k < NUM_CLS; k++) acc_d[k] = acc_q[k] + dot[k];
                  row_cnt_d = row_cnt_q + AW'(1);
               end
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_FETCH;
         row_cnt_q   <= '0;
         acc_q       <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_cnt_q   <= row_cnt_d;
         acc_q       <= acc_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
      end
   end

`ifdef FC_ARGMAX_EN
   logic [CW-1:0]          cls_q, cls_d;
   logic signed [ACC_W-1:0] best_val;

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      cls_d    = cls_q;
      best_val = $signed(score[0]);
      if (row_fire && last_row) begin
         cls_d = '0;
         for (int k = 1; k < NUM_CLS; k++) begin
            if ($signed(score[k]) > best_val) begin
               best_val = $signed(score[k]);
               cls_d    = CW'(k);
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) cls_q <= '0;
      else          cls_q <= cls_d;
   end

   assign o_cls = cls_q;
`else
   assign o_cls = '0;
`endif

endmodule

// File: tb/tb_fc_stream_engine.sv
// tb/tb_fc_stream_engine.sv - directed self-checking bench for fc_stream_engine
module tb_fc_stream_engine;

   localparam int ROW_LEN  = 26;
   localparam int NUM_ROWS = 26;
   localparam int NUM_CLS  = 10;
   localparam int IN_W     = 32;
   localparam int WT_W     = 8;
   localparam int ACC_W    = 32;
   localparam int WROW     = NUM_CLS * ROW_LEN * WT_W;

   logic                        clk = 1'b0;
   logic                        rst_n = 1'b0;
   logic                        row_valid = 1'b0;
   logic                        row_ready;
   logic [ROW_LEN*IN_W-1:0]     row_data = '0;
   logic                        wt_rd;
   logic [4:0]                  wt_addr;
   logic [WROW-1:0]             wt_data;
   logic [NUM_CLS*WT_W-1:0]     bias = '0;
   logic                        res_valid;
   logic                        res_ready = 1'b0;
   logic [NUM_CLS*ACC_W-1:0]    res;
   logic [3:0]                  cls;

   logic [WROW-1:0] wmem [NUM_ROWS];
   logic [4:0]      rd_addr_q = '0;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (wt_rd) rd_addr_q <= wt_addr;
   assign wt_data = wmem[rd_addr_q];

   fc_stream_engine dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_row_valid (row_valid),
      .o_row_ready (row_ready),
      .i_row_data  (row_data),
      .o_wt_rd     (wt_rd),
      .o_wt_addr   (wt_addr),
      .i_wt_data   (wt_data),
      .i_bias      (bias),
      .o_res_valid (res_valid),
      .i_res_ready (res_ready),
      .o_res       (res),
      .o_cls       (cls)
   );

   task automatic fill_weights(input logic [7:0] v);
      for (int r = 0; r < NUM_ROWS; r++)
         for (int i = 0; i < NUM_CLS*ROW_LEN; i++) wmem[r][i*WT_W +: WT_W] = v;
   endtask

   task automatic set_row(input logic [31:0] v);
      for (int j = 0; j < ROW_LEN; j++) row_data[j*IN_W +: IN_W] = v;
   endtask

   task automatic send_rows(input int n, output int addr_err, output int timeouts);
      int b;
      addr_err = 0;
      timeouts = 0;
      for (int r = 0; r < n; r++) begin
         row_valid = 1'b1;
         b = 0;
         while (row_ready !== 1'b1 && b < 20) begin
            @(negedge clk);
            b++;
         end
         if (b >= 20) timeouts++;
         if (wt_addr !== 5'(r)) addr_err++;
         @(negedge clk);
         row_valid = 1'b0;
      end
   endtask

   task automatic wait_res(output bit ok);
      int b;
      b = 0;
      while (res_valid !== 1'b1 && b < 200) begin
         @(negedge clk);
         b++;
      end
      ok = (res_valid === 1'b1);
   endtask

   task automatic take_result();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_total++; if (row_ready !== 1'b0) $display("FAIL rst_row_ready got=%b exp=0", row_ready); else n_pass++;
      n_total++; if (wt_rd !== 1'b0) $display("FAIL rst_wt_rd got=%b exp=0", wt_rd); else n_pass++;
      n_total++; if (wt_addr !== 5'd0) $display("FAIL rst_wt_addr got=%0d exp=0", wt_addr); else n_pass++;
      n_total++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid got=%b exp=0", res_valid); else n_pass++;
      n_total++; if (res !== '0) $display("FAIL rst_res got=%h exp=0", res); else n_pass++;
      n_total++; if (cls !== 4'd0) $display("FAIL rst_cls got=%0d exp=0", cls); else n_pass++;
      rst_n = 1'b1;
      #1;
      n_total++; if (wt_rd !== 1'b1) $display("FAIL rst_first_fetch got=%b exp=1", wt_rd); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_ones();
      int ae, to;
      bit ok;
      fill_weights(8'd1);
      set_row(32'd1);
      bias = '0;
      send_rows(NUM_ROWS, ae, to);
      n_total++; if (to != 0) $display("FAIL ones_row_timeout got=%0d exp=0", to); else n_pass++;
      n_total++; if (ae != 0) $display("FAIL ones_addr_seq bad_addrs=%0d exp=0", ae); else n_pass++;
      wait_res(ok);
      n_total++; if (!ok) $display("FAIL ones_res_timeout got=0 exp=1"); else n_pass++;
      for (int k = 0; k < NUM_CLS; k++) begin
         n_total++;
         if (res[k*ACC_W +: ACC_W] !== 32'd676)
            $display("FAIL ones_res%0d got=%0d exp=676", k, res[k*ACC_W +: ACC_W]);
         else n_pass++;
      end
      take_result();
      n_total++; if (res_valid !== 1'b0) $display("FAIL ones_take got=%b exp=0", res_valid); else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      int ae, to, b;
      bit ok;
      fill_weights(8'd1);
      set_row(32'd1);
      bias = '0;
      send_rows(7, ae, to);
      row_valid = 1'b1;
      b = 0;
      while (row_ready !== 1'b1 && b < 20) begin
         @(negedge clk);
         b++;
      end
      n_total++; if (wt_addr !== 5'd7) $display("FAIL mid_addr_before got=%0d exp=7", wt_addr); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++; if (row_ready !== 1'b0) $display("FAIL mid_row_ready got=%b exp=0", row_ready); else n_pass++;
      n_total++; if (wt_addr !== 5'd0) $display("FAIL mid_wt_addr got=%0d exp=0", wt_addr); else n_pass++;
      n_total++; if (res !== '0) $display("FAIL mid_res got=%h exp=0", res); else n_pass++;
      row_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_total++; if (wt_addr !== 5'd0) $display("FAIL mid_addr_after got=%0d exp=0", wt_addr); else n_pass++;
      send_rows(NUM_ROWS, ae, to);
      wait_res(ok);
      n_total++; if (!ok || to != 0) $display("FAIL mid_res_timeout got=%0d exp=1", ok); else n_pass++;
      n_total++;
      if (res[0 +: ACC_W] !== 32'd676) $display("FAIL mid_partial_discard got=%0d exp=676", res[0 +: ACC_W]);
      else n_pass++;
      take_result();
   endtask

   task automatic test_signed();
      int ae, to;
      bit ok;
      fill_weights(8'd0);
      for (int r = 0; r < NUM_ROWS; r++) wmem[r][(2*ROW_LEN + 0)*WT_W +: WT_W] = 8'h80;
      set_row(32'd0);
      row_data[0 +: IN_W] = 32'hFFFF_FFFD;
      bias = '0;
      bias[2*WT_W +: WT_W] = 8'hFB;
      send_rows(NUM_ROWS, ae, to);
      wait_res(ok);
      n_total++; if (!ok) $display("FAIL signed_res_timeout got=0 exp=1"); else n_pass++;
      n_total++;
      if (res[2*ACC_W +: ACC_W] !== 32'd9979) $display("FAIL signed_res2 got=%0d exp=9979", res[2*ACC_W +: ACC_W]);
      else n_pass++;
      n_total++;
      if (res[0 +: ACC_W] !== 32'd0) $display("FAIL signed_res0 got=%0d exp=0", res[0 +: ACC_W]);
      else n_pass++;
      n_total++;
      if (res[3*ACC_W +: ACC_W] !== 32'd0) $display("FAIL signed_res3 got=%0d exp=0", res[3*ACC_W +: ACC_W]);
      else n_pass++;
      take_result();
   endtask

   task automatic test_backpressure();
      int ae, to, stall_bad;
      bit ok;
      fill_weights(8'd1);
      bias = '0;
      set_row(32'd1);
      send_rows(NUM_ROWS, ae, to);
      wait_res(ok);
      n_total++; if (!ok) $display("FAIL bp_first_timeout got=0 exp=1"); else n_pass++;
      set_row(32'd2);
      send_rows(NUM_ROWS - 1, ae, to);
      n_total++; if (to != 0 || ae != 0) $display("FAIL bp_rows_while_pending timeouts=%0d bad_addrs=%0d exp=0", to, ae); else n_pass++;
      row_valid = 1'b1;
      stall_bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (row_ready !== 1'b0) stall_bad++;
      end
      n_total++; if (stall_bad != 0) $display("FAIL bp_stall ready_high_cycles=%0d exp=0", stall_bad); else n_pass++;
      n_total++; if (wt_addr !== 5'd25) $display("FAIL bp_stall_addr got=%0d exp=25", wt_addr); else n_pass++;
      n_total++;
      if (res_valid !== 1'b1 || res[0 +: ACC_W] !== 32'd676)
         $display("FAIL bp_hold got_valid=%b got_res=%0d exp=1/676", res_valid, res[0 +: ACC_W]);
      else n_pass++;
      res_ready = 1'b1;
      #1;
      n_total++; if (row_ready !== 1'b1) $display("FAIL bp_release got=%b exp=1", row_ready); else n_pass++;
      @(negedge clk);
      row_valid = 1'b0;
      res_ready = 1'b0;
      n_total++; if (res_valid !== 1'b1) $display("FAIL bp_valid_stays got=%b exp=1", res_valid); else n_pass++;
      n_total++;
      if (res[0 +: ACC_W] !== 32'd1352 || res[9*ACC_W +: ACC_W] !== 32'd1352)
         $display("FAIL bp_second_res got=%0d/%0d exp=1352", res[0 +: ACC_W], res[9*ACC_W +: ACC_W]);
      else n_pass++;
      take_result();
      n_total++; if (res_valid !== 1'b0) $display("FAIL bp_final_take got=%b exp=0", res_valid); else n_pass++;
   endtask

   task automatic test_wrap();
      int ae, to;
      bit ok;
      fill_weights(8'h7F);
      set_row(32'h7FFF_FFFF);
      bias = '0;
      send_rows(NUM_ROWS, ae, to);
      wait_res(ok);
      n_total++; if (!ok) $display("FAIL wrap_res_timeout got=0 exp=1"); else n_pass++;
      n_total++;
      if (res[0 +: ACC_W] !== 32'hFFFE_B0A4) $display("FAIL wrap_res0 got=%h exp=fffeb0a4", res[0 +: ACC_W]);
      else n_pass++;
      n_total++;
      if (res[9*ACC_W +: ACC_W] !== 32'hFFFE_B0A4) $display("FAIL wrap_res9 got=%h exp=fffeb0a4", res[9*ACC_W +: ACC_W]);
      else n_pass++;
      take_result();
   endtask

   task automatic test_argmax();
      int ae, to;
      bit ok;
      fill_weights(8'd0);
      set_row(32'd0);
      for (int k = 0; k < NUM_CLS; k++) bias[k*WT_W +: WT_W] = 8'hFF;
      bias[0*WT_W +: WT_W] = 8'd5;
      bias[1*WT_W +: WT_W] = 8'd9;
      bias[2*WT_W +: WT_W] = 8'd9;
      send_rows(NUM_ROWS, ae, to);
      wait_res(ok);
      n_total++; if (!ok) $display("FAIL argmax_res_timeout got=0 exp=1"); else n_pass++;
      n_total++;
      if (res[1*ACC_W +: ACC_W] !== 32'd9 || res[3*ACC_W +: ACC_W] !== 32'hFFFF_FFFF)
         $display("FAIL argmax_scores got=%0d/%h exp=9/ffffffff", res[1*ACC_W +: ACC_W], res[3*ACC_W +: ACC_W]);
      else n_pass++;
`ifdef FC_ARGMAX_EN
      n_total++; if (cls !== 4'd1) $display("FAIL argmax_cls got=%0d exp=1", cls); else n_pass++;
`else
      n_total++; if (cls !== 4'd0) $display("FAIL argmax_cls_off got=%0d exp=0", cls); else n_pass++;
`endif
      take_result();
   endtask

   initial begin
      test_reset();
      test_ones();
      test_reset_mid_frame();
      test_signed();
      test_backpressure();
      test_wrap();
      test_argmax();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
